// File: rtl/data_mem_responder.sv
// Word-addressed single-port data RAM answering core load/store requests.
// Latency: request sampled at edge N -> ready high in the cycle after edge N+WAIT_CYCLES+1.
// Backpressure: the core holds its request until ready; requests are ignored outside IDLE.
module data_mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("data_mem_responder: WAIT_CYCLES must be 0..15");
  end

  // Upper address bits alias onto the decoded range.
  if (ADDR_W < 16) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[15:ADDR_W];
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;
  logic                cap_wr;
  logic                cap_both;
  logic                commit;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign commit = (state == BUSY) && (cnt == 4'd0);

  // RAM contents survive reset; a store in flight when reset hits never commits.
  always_ff @(posedge clk) begin
    if (!rst && commit && cap_wr) begin
      mem[cap_addr] <= cap_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wr    <= 1'b0;
      cap_both  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          if (mem_read || mem_write) begin
            cap_addr  <= addr[ADDR_W-1:0];
            cap_wdata <= wdata;
            cap_wr    <= mem_write;
            cap_both  <= mem_read && mem_write;
            cnt       <= 4'(WAIT_CYCLES);
            busy      <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            ready <= 1'b1;
            err   <= cap_both;
            if (!cap_wr) begin
              rdata <= mem[cap_addr];
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a scoreboard of expected completions.
// Two instances: WAIT_CYCLES=2 (main) and WAIT_CYCLES=0 (zero-wait latency).
module tb_data_mem_responder;

  localparam int W0 = 2;
  localparam int W1 = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd0, wr0, rd1, wr1;
  logic [15:0] a0, a1, d0, d1;
  logic [15:0] rdata0, rdata1;
  logic        ready0, ready1, busy0, busy1, err0, err1;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(W0)) dut_w2 (
    .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0), .addr(a0), .wdata(d0),
    .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
  );

  data_mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(W1)) dut_w0 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1), .addr(a1), .wdata(d1),
    .rdata(rdata1), .ready(ready1), .busy(busy1), .err(err1)
  );

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mdl [2][256];
  logic [15:0] last_rd [2];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] d);
    if (sel == 1'b0) begin
      rd0 = rd; wr0 = wr; a0 = a; d0 = d;
    end else begin
      rd1 = rd; wr1 = wr; a1 = a; d1 = d;
    end
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? ready1 : ready0;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? busy1 : busy0;
  endfunction

  function automatic logic get_err(input bit sel);
    return sel ? err1 : err0;
  endfunction

  function automatic logic [15:0] get_rdata(input bit sel);
    return sel ? rdata1 : rdata0;
  endfunction

  // A store (including read+write) leaves rdata at its previous value.
  task automatic expect_push(input bit sel, input logic rd, input logic wr,
                             input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.err = rd & wr;
    if (wr) begin
      mdl[sel][a[7:0]] = d;
      e.rdata = last_rd[sel];
    end else begin
      e.rdata = mdl[sel][a[7:0]];
    end
    last_rd[sel] = e.rdata;
    sb.push_back(e);
  endtask

  // Request is dropped right after it is sampled; completion must still arrive.
  task automatic txn(input bit sel, input logic rd, input logic wr,
                     input logic [15:0] a, input logic [15:0] d,
                     input int exp_lat, input string tag);
    int   n;
    int   busy_low;
    bit   got;
    exp_t e;
    drive(sel, rd, wr, a, d);
    expect_push(sel, rd, wr, a, d);
    got      = 1'b0;
    busy_low = 0;
    for (n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) drive(sel, 1'b0, 1'b0, a, d);
      if (get_ready(sel)) begin
        got = 1'b1;
        break;
      end
      if (!get_busy(sel)) busy_low++;
    end
    if (!got) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout: observed no ready expected ready within 40 cycles", tag);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk({tag, "_lat"}, n, exp_lat);
      chk({tag, "_rdata"}, get_rdata(sel), e.rdata);
      chk({tag, "_err"}, get_err(sel), e.err);
      chk({tag, "_busy_wait"}, busy_low, 0);
      chk({tag, "_busy_done"}, get_busy(sel), 1'b1);
      @(posedge clk); #1;
      chk({tag, "_ready_1cyc"}, get_ready(sel), 1'b0);
      chk({tag, "_err_1cyc"}, get_err(sel), 1'b0);
      chk({tag, "_busy_idle"}, get_busy(sel), 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   t[3];
    int   k;
    int   nready;
    exp_t e;

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    last_rd[0] = 16'h0;
    last_rd[1] = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_ready", ready0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_err", err0, 1'b0);
    chk("rst_rdata", rdata0, 16'h0);

    // 1: store, 4-cycle latency with WAIT=2
    txn(1'b0, 1'b0, 1'b1, 16'h0005, 16'hBEEF, W0 + 2, "st_beef");

    // 2: load back, rdata held over idle cycles
    txn(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, W0 + 2, "ld_beef");
    repeat (10) @(posedge clk);
    #1 chk("hold_rdata", rdata0, 16'hBEEF);

    // 3: read+write together acts as store and flags err
    txn(1'b0, 1'b1, 1'b1, 16'h0005, 16'h0001, W0 + 2, "both");
    txn(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, W0 + 2, "ld_0001");

    // 4: reset during first BUSY cycle aborts the store
    txn(1'b0, 1'b0, 1'b1, 16'h0007, 16'h1234, W0 + 2, "st_1234");
    drive(1'b0, 1'b0, 1'b1, 16'h0007, 16'hFFFF);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 16'h0007, 16'hFFFF);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd[0] = 16'h0;
    last_rd[1] = 16'h0;
    chk("abort_busy", busy0, 1'b0);
    chk("abort_rdata", rdata0, 16'h0);
    nready = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ready0) nready++;
    end
    chk("abort_no_ready", nready, 0);
    txn(1'b0, 1'b1, 1'b0, 16'h0007, 16'h0000, W0 + 2, "ld_1234");

    // 5: held load repeats every WAIT+3 cycles
    drive(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000);
    for (int i = 0; i < 3; i++) expect_push(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000);
    k = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (ready0) begin
        t[k] = c;
        e = sb.pop_front();
        chk("hold_pulse_rdata", rdata0, e.rdata);
        k++;
        if (k == 3) begin
          drive(1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000);
          break;
        end
      end
    end
    if (k < 3) begin
      checks++;
      errors++;
      $error("FAIL hold_timeout: observed %0d pulses expected 3", k);
      sb.delete();
    end else begin
      chk("hold_first_lat", t[0], W0 + 2);
      chk("hold_gap1", t[1] - t[0], W0 + 3);
      chk("hold_gap2", t[2] - t[1], W0 + 3);
    end
    repeat (3) @(posedge clk);
    #1;

    // 6: address aliasing, then zero-wait instance
    txn(1'b0, 1'b0, 1'b1, 16'h0105, 16'hA5A5, W0 + 2, "alias_st");
    txn(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, W0 + 2, "alias_ld");
    txn(1'b1, 1'b0, 1'b1, 16'h0105, 16'hA5A5, W1 + 2, "w0_st");
    txn(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000, W1 + 2, "w0_ld");

    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
